program_sequencer: RTL and testbench

Parametrised successor to the CPU's 4-bit program counter: holds the instruction address, increments on fetch, and drives it onto the shared bus on request. It adds conditional jump-load qualified by ALU flags and a hardware return-address stack for CALL/RET. It sits between the control block, which supplies the strobes, the ALU, which supplies CF/ZF, and the bus, which supplies jump targets and receives the PC value.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/return_stack.sv | 73 +++++++
 rtl/program_sequencer.sv | 118 +++++++++++
 tb/tb_program_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: jump-condition encodings and stack sizing helpers.
package cpu_pkg;

    // Jump condition selected by cond_sel.
    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_CF     = 2'b01,
        COND_ZF     = 2'b10,
        COND_NZ     = 2'b11
    } cond_e;

    // Width needed to count 0..depth valid stack entries (never less than 1).
    function automatic int sp_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) < (depth + 1)) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage : cpu_pkg

// File: rtl/return_stack.sv
// Hardware return-address stack: registered entry array plus a level pointer.
// Push when full and pop when empty are ignored; full/empty let the caller flag them.
module return_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  din,
    output logic [ADDR_W-1:0]                  dout,
    output logic                               full,
    output logic                               empty,
    output logic [sp_width(STACK_DEPTH)-1:0]   level
);

    localparam int LVL_W = sp_width(STACK_DEPTH);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [LVL_W-1:0]  top_lvl;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    assign full    = (level_q == LVL_W'(STACK_DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;

    // Top-of-stack index is only meaningful when non-empty; park it at 0 otherwise.
    assign top_lvl = empty ? '0 : (level_q - LVL_W'(1));
    assign wr_idx  = level_q[IDX_W-1:0];
    assign rd_idx  = top_lvl[IDX_W-1:0];
    assign dout    = mem_q[rd_idx];
    assign level   = level_q;

    // Next level: pop takes precedence over push.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        level_d = level_q;
        if (do_pop) begin
            level_d = level_q - LVL_W'(1);
        end else if (do_push) begin
            level_d = level_q + LVL_W'(1);
        end
    end

    // Level pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Entry array write on an accepted push.
    // NOTE: the array is deliberately not reset; the level pointer alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule : return_stack

// File: rtl/program_sequencer.sv
// Program sequencer: PC register with increment, flag-qualified jump-load,
// CALL/RET through a return-address stack, and a gated bus driver.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cp,
    input  logic                               ep,
    input  logic                               lp,
    input  logic [1:0]                         cond_sel,
    input  logic                               cf,
    input  logic                               zf,
    input  logic                               call,
    input  logic                               ret,
    input  logic [ADDR_W-1:0]                  bus_in,
    output logic [ADDR_W-1:0]                  bus_out,
    output logic                               bus_oe,
    output logic [ADDR_W-1:0]                  pc,
    output logic [sp_width(STACK_DEPTH)-1:0]   sp_level,
    output logic                               stk_ovf,
    output logic                               stk_unf
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic              cond_true;
    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_full;
    logic              stk_empty;

    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_q),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .level (sp_level)
    );

    // Jump condition mux over the ALU flags sampled at this edge.
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond_sel))
            COND_ALWAYS: cond_true = 1'b1;
            COND_CF:     cond_true = cf;
            COND_ZF:     cond_true = zf;
            COND_NZ:     cond_true = !zf;
            default:     cond_true = 1'b0;
        endcase
    end

    // Priority decode ret > call > lp > cp; exactly one action per cycle.
    always_comb begin
        pc_d     = pc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (ret) begin
            if (stk_empty) begin
                unf_d = 1'b1;
            end else begin
                stk_pop = 1'b1;
                pc_d    = stk_dout;
            end
        end else if (call) begin
            if (stk_full) begin
                ovf_d = 1'b1;
            end else begin
                stk_push = 1'b1;
                pc_d     = bus_in;
            end
        end else if (lp) begin
            // A false condition still consumes the slot, so cp is not applied.
            if (cond_true) begin
                pc_d = bus_in;
            end
        end else if (cp) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC and sticky stack-error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc      = pc_q;
    assign bus_oe  = ep;
    assign bus_out = ep ? pc_q : '0;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule : program_sequencer

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: stimulus pushes expected state,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_program_sequencer;

    localparam int ADDR_W      = 4;
    localparam int STACK_DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             cp, ep, lp, cf, zf, call, ret;
    logic [1:0]       cond_sel;
    logic [3:0]       bus_in;
    logic [3:0]       bus_out;
    logic             bus_oe;
    logic [3:0]       pc;
    logic [2:0]       sp_level;
    logic             stk_ovf, stk_unf;

    typedef struct {
        string      name;
        logic [3:0] pc;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
        logic [3:0] bus;
        logic       oe;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    program_sequencer #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cp       (cp),
        .ep       (ep),
        .lp       (lp),
        .cond_sel (cond_sel),
        .cf       (cf),
        .zf       (zf),
        .call     (call),
        .ret      (ret),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .pc       (pc),
        .sp_level (sp_level),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, ".pc"},       32'(pc),       32'(e.pc));
            check({e.name, ".sp_level"}, 32'(sp_level), 32'(e.sp));
            check({e.name, ".stk_ovf"},  32'(stk_ovf),  32'(e.ovf));
            check({e.name, ".stk_unf"},  32'(stk_unf),  32'(e.unf));
            check({e.name, ".bus_out"},  32'(bus_out),  32'(e.bus));
            check({e.name, ".bus_oe"},   32'(bus_oe),   32'(e.oe));
        end
    end

    task automatic push_exp(input string name, input logic [3:0] e_pc, input logic [2:0] e_sp,
                            input logic e_ovf, input logic e_unf);
        exp_t e;
        e.name = name;
        e.pc   = e_pc;
        e.sp   = e_sp;
        e.ovf  = e_ovf;
        e.unf  = e_unf;
        e.bus  = ep ? e_pc : 4'h0;
        e.oe   = ep;
        sb.push_back(e);
    endtask

    task automatic idle();
        cp = 0; ep = 0; lp = 0; cond_sel = 2'b00; cf = 0; zf = 0;
        call = 0; ret = 0; bus_in = 4'h0;
    endtask

    // Drive one cycle of strobes, then queue the expected post-edge state.
    task automatic step(input string name,
                        input logic i_cp, input logic i_ep, input logic i_lp, input logic [1:0] i_cs,
                        input logic i_cf, input logic i_zf, input logic i_call, input logic i_ret,
                        input logic [3:0] i_bus,
                        input logic [3:0] e_pc, input logic [2:0] e_sp, input logic e_ovf, input logic e_unf);
        cp = i_cp; ep = i_ep; lp = i_lp; cond_sel = i_cs; cf = i_cf; zf = i_zf;
        call = i_call; ret = i_ret; bus_in = i_bus;
        @(posedge clk);
        #1;
        push_exp(name, e_pc, e_sp, e_ovf, e_unf);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1;
        push_exp("reset", 4'h0, 3'd0, 0, 0);
        @(negedge clk);
        #1;

        //                    name         cp ep lp cs     cf zf cl rt bus     pc    sp  ov un
        for (int i = 0; i < 17; i++) begin
            step("cp_wrap",     1, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 4'(i + 1), 3'd0, 0, 0);
        end
        step("ep_hold",         0, 1, 0, 2'b00, 0, 0, 0, 0, 4'h0, 4'h1, 3'd0, 0, 0);
        step("ep_cp",           1, 1, 0, 2'b00, 0, 0, 0, 0, 4'h0, 4'h2, 3'd0, 0, 0);

        step("lp_cf0",          1, 0, 1, 2'b01, 0, 0, 0, 0, 4'hA, 4'h2, 3'd0, 0, 0);
        step("lp_cf1",          1, 0, 1, 2'b01, 1, 0, 0, 0, 4'hA, 4'hA, 3'd0, 0, 0);
        step("lp_zf0",          1, 0, 1, 2'b10, 0, 0, 0, 0, 4'h5, 4'hA, 3'd0, 0, 0);
        step("lp_zf1",          1, 0, 1, 2'b10, 0, 1, 0, 0, 4'h5, 4'h5, 3'd0, 0, 0);
        step("lp_nz_zf1",       1, 0, 1, 2'b11, 0, 1, 0, 0, 4'hC, 4'h5, 3'd0, 0, 0);
        step("lp_nz_zf0",       1, 0, 1, 2'b11, 0, 0, 0, 0, 4'hC, 4'hC, 3'd0, 0, 0);
        step("lp_always",       0, 0, 1, 2'b00, 0, 0, 0, 0, 4'h3, 4'h3, 3'd0, 0, 0);

        step("call9",           0, 0, 0, 2'b00, 0, 0, 1, 0, 4'h9, 4'h9, 3'd1, 0, 0);
        step("ret9",            0, 0, 0, 2'b00, 0, 0, 0, 1, 4'h0, 4'h3, 3'd0, 0, 0);

        step("nest_call1",      0, 0, 0, 2'b00, 0, 0, 1, 0, 4'h1, 4'h1, 3'd1, 0, 0);
        step("nest_call2",      0, 0, 0, 2'b00, 0, 0, 1, 0, 4'h2, 4'h2, 3'd2, 0, 0);
        step("nest_call3",      0, 0, 0, 2'b00, 0, 0, 1, 0, 4'h4, 4'h4, 3'd3, 0, 0);
        step("nest_call4",      0, 0, 0, 2'b00, 0, 0, 1, 0, 4'h8, 4'h8, 3'd4, 0, 0);
        step("nest_call5_ovf",  0, 1, 0, 2'b00, 0, 0, 1, 0, 4'hF, 4'h8, 3'd4, 1, 0);
        step("nest_ret1",       0, 0, 0, 2'b00, 0, 0, 0, 1, 4'h0, 4'h4, 3'd3, 1, 0);
        step("nest_ret2",       0, 0, 0, 2'b00, 0, 0, 0, 1, 4'h0, 4'h2, 3'd2, 1, 0);
        step("nest_ret3",       0, 0, 0, 2'b00, 0, 0, 0, 1, 4'h0, 4'h1, 3'd1, 1, 0);
        step("nest_ret4",       0, 0, 0, 2'b00, 0, 0, 0, 1, 4'h0, 4'h3, 3'd0, 1, 0);

        step("ret_empty",       0, 0, 0, 2'b00, 0, 0, 0, 1, 4'h0, 4'h3, 3'd0, 1, 1);
        step("unf_sticky",      1, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 4'h4, 3'd0, 1, 1);
        step("all_empty",       1, 0, 1, 2'b00, 0, 0, 1, 1, 4'hD, 4'h4, 3'd0, 1, 1);
        step("call7",           0, 0, 0, 2'b00, 0, 0, 1, 0, 4'h7, 4'h7, 3'd1, 1, 1);
        step("all_strobes",     1, 1, 1, 2'b00, 0, 0, 1, 1, 4'hD, 4'h4, 3'd0, 1, 1);

        step("pre_rst_cp",      1, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 4'h5, 3'd0, 1, 1);
        step("pre_rst_call",    0, 0, 0, 2'b00, 0, 0, 1, 0, 4'hB, 4'hB, 3'd1, 1, 1);
        idle();
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        push_exp("async_rst", 4'h0, 3'd0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1;
        step("post_rst_cp",     1, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 4'h1, 3'd0, 0, 0);

        idle();
        repeat (2) @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_program_sequencer
